hbmc_bus_sequencer: RTL and testbench

HBMC_BUS_SEQUENCER -- requirements
Module: hbmc_bus_sequencer

---
 rtl/hbmc_pkg.sv | 37 +++
 rtl/hbmc_bus_sequencer.sv | 164 ++++++++++++++++
 tb/tb_hbmc_bus_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hbmc_pkg.sv
// Shared types and command/address word layout for the HyperBus sequencer.
package hbmc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CA0,
        CA1,
        CA2,
        LAT,
        WR,
        RD,
        HOLD,
        RWR
    } state_t;

    localparam int unsigned CA_RW_BIT    = 47;
    localparam int unsigned CA_AS_BIT    = 46;
    localparam int unsigned CA_BURST_BIT = 45;
    localparam int unsigned CA_ROW_MSB   = 44;
    localparam int unsigned CA_ROW_LSB   = 16;
    localparam int unsigned CA_COL_MSB   = 2;

    typedef logic [8:0] len_t;

    // Linear-burst memory-space CA word; column bits [15:3] stay reserved zero.
    function automatic logic [47:0] ca_word(input logic rd, input logic [31:0] addr);
        logic [47:0] w;
        w                         = '0;
        w[CA_RW_BIT]              = rd;
        w[CA_AS_BIT]              = 1'b0;
        w[CA_BURST_BIT]           = 1'b1;
        w[CA_ROW_MSB:CA_ROW_LSB]  = addr[31:3];
        w[CA_COL_MSB:0]           = addr[2:0];
        return w;
    endfunction

endpackage

// File: rtl/hbmc_bus_sequencer.sv
// HyperBus transaction sequencer: CA, latency, data burst, CS# recovery.
// Optional read-idle timeout enabled by defining HBMC_RD_TIMEOUT_EN.
module hbmc_bus_sequencer #(
    parameter int unsigned LATENCY    = 6,
    parameter int unsigned RWR_CYCLES = 4,
    parameter int unsigned RD_TIMEOUT = 32
) (
    input  logic        iserdes_clkdiv,
    input  logic        arst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic [1:0]  wr_mask,
    input  logic        rec_valid,
    input  logic [15:0] rec_data,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        rd_last,
    input  logic        rwds_lat_x2,
    output logic        hb_cs_n,
    output logic        hb_ck_en,
    output logic [15:0] hb_dq_sdr,
    output logic        hb_dq_t,
    output logic [1:0]  hb_rwds_sdr,
    output logic        hb_rwds_t,
    output logic        busy,
    output logic        err_timeout
);
    import hbmc_pkg::*;

    state_t      state, nxt;
    logic [1:0]  init_cnt;
    logic        rd_q;
    logic [31:0] addr_q;
    len_t        word_cnt;
    logic [3:0]  lat_cnt;
    logic [3:0]  rwr_cnt;
    logic [47:0] ca;
    logic        accept;
    logic        last_word;
    logic        timeout_hit;

    assign ca        = ca_word(rd_q, addr_q);
    assign last_word = (word_cnt == len_t'(1));
    assign cmd_ready = (state == IDLE) && (init_cnt == 2'd2);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);

`ifdef HBMC_RD_TIMEOUT_EN
    logic [7:0] to_cnt;

    assign timeout_hit = (state == RD) && !rec_valid && (to_cnt == 8'(RD_TIMEOUT - 1));

    always_ff @(posedge iserdes_clkdiv or posedge arst) begin
        if (arst) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            to_cnt      <= (state == RD && !rec_valid) ? to_cnt + 8'd1 : '0;
            err_timeout <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge iserdes_clkdiv or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (accept) nxt = CA0;
            CA0:  nxt = CA1;
            CA1:  nxt = CA2;
            CA2:  nxt = LAT;
            LAT:  if (lat_cnt == 4'd0) nxt = rd_q ? RD : WR;
            WR:   if (wr_valid && last_word) nxt = HOLD;
            RD:   if ((rec_valid && last_word) || timeout_hit) nxt = HOLD;
            HOLD: nxt = RWR;
            RWR:  if (rwr_cnt == 4'd0) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Init window keeps cmd_ready low while the ISERDES output is still invalid.
    always_ff @(posedge iserdes_clkdiv or posedge arst) begin
        if (arst) begin
            init_cnt <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            word_cnt <= '0;
            lat_cnt  <= '0;
            rwr_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else begin
            if (init_cnt != 2'd2) init_cnt <= init_cnt + 2'd1;
            unique case (state)
                IDLE: if (accept) begin
                    rd_q     <= cmd_rd;
                    addr_q   <= cmd_addr;
                    word_cnt <= (cmd_len == 8'd0) ? len_t'(256) : {1'b0, cmd_len};
                end
                CA2:  lat_cnt  <= rwds_lat_x2 ? 4'(2 * LATENCY - 3) : 4'(LATENCY - 3);
                LAT:  lat_cnt  <= lat_cnt - 4'd1;
                WR:   if (wr_valid) word_cnt <= word_cnt - len_t'(1);
                RD:   if (rec_valid) word_cnt <= word_cnt - len_t'(1);
                HOLD: rwr_cnt  <= 4'(RWR_CYCLES - 1);
                RWR:  rwr_cnt  <= rwr_cnt - 4'd1;
                default: ;
            endcase
            rd_valid <= (state == RD) && rec_valid;
            rd_last  <= (state == RD) && rec_valid && last_word;
            if (state == RD && rec_valid) rd_data <= rec_data;
        end
    end

    always_comb begin
        hb_cs_n     = 1'b1;
        hb_ck_en    = 1'b0;
        hb_dq_t     = 1'b1;
        hb_dq_sdr   = '0;
        hb_rwds_t   = 1'b1;
        hb_rwds_sdr = '0;
        wr_ready    = 1'b0;
        unique case (state)
            CA0: begin
                hb_cs_n = 1'b0; hb_ck_en = 1'b1; hb_dq_t = 1'b0; hb_dq_sdr = ca[47:32];
            end
            CA1: begin
                hb_cs_n = 1'b0; hb_ck_en = 1'b1; hb_dq_t = 1'b0; hb_dq_sdr = ca[31:16];
            end
            CA2: begin
                hb_cs_n = 1'b0; hb_ck_en = 1'b1; hb_dq_t = 1'b0; hb_dq_sdr = ca[15:0];
            end
            LAT, RD: begin
                hb_cs_n = 1'b0; hb_ck_en = 1'b1;
            end
            // Bus clock stalls while the write stream has no data.
            WR: begin
                hb_cs_n     = 1'b0;
                hb_ck_en    = wr_valid;
                hb_dq_t     = 1'b0;
                hb_dq_sdr   = wr_data;
                hb_rwds_t   = 1'b0;
                hb_rwds_sdr = wr_mask;
                wr_ready    = 1'b1;
            end
            HOLD: hb_cs_n = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hbmc_bus_sequencer.sv
// Randomized self-checking bench for hbmc_bus_sequencer against a cycle timeline model.
module tb_hbmc_bus_sequencer;

    localparam int LATENCY    = 6;
    localparam int RWR_CYCLES = 4;
    localparam int RD_TIMEOUT = 32;

    logic        iserdes_clkdiv = 1'b0;
    logic        arst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rd = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_mask = '0;
    logic        rec_valid = 1'b0;
    logic [15:0] rec_data = '0;
    logic        rd_valid, rd_last;
    logic [15:0] rd_data;
    logic        rwds_lat_x2 = 1'b0;
    logic        hb_cs_n, hb_ck_en, hb_dq_t, hb_rwds_t, busy, err_timeout;
    logic [15:0] hb_dq_sdr;
    logic [1:0]  hb_rwds_sdr;

    always #5 iserdes_clkdiv = ~iserdes_clkdiv;

    hbmc_bus_sequencer #(
        .LATENCY    (LATENCY),
        .RWR_CYCLES (RWR_CYCLES),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .iserdes_clkdiv (iserdes_clkdiv),
        .arst           (arst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rd         (cmd_rd),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .wr_mask        (wr_mask),
        .rec_valid      (rec_valid),
        .rec_data       (rec_data),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_last        (rd_last),
        .rwds_lat_x2    (rwds_lat_x2),
        .hb_cs_n        (hb_cs_n),
        .hb_ck_en       (hb_ck_en),
        .hb_dq_sdr      (hb_dq_sdr),
        .hb_dq_t        (hb_dq_t),
        .hb_rwds_sdr    (hb_rwds_sdr),
        .hb_rwds_t      (hb_rwds_t),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    typedef enum {P_CA, P_LAT, P_DATA, P_HOLD, P_RWR} ph_t;

    // Reset-value vector: cs_n,ck_en,dq_t,rwds_t,wr_ready,busy,cmd_ready,rd_valid,err,dq,rwds
    localparam logic [26:0] RST_VEC = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 2'b0};

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] obs_ca [3];
    int obs_rv, obs_last_idx, obs_wr, obs_stall, obs_lat, obs_err, obs_cs_high;

    function automatic logic [26:0] obs_vec();
        return {hb_cs_n, hb_ck_en, hb_dq_t, hb_rwds_t, wr_ready, busy, cmd_ready,
                rd_valid, err_timeout, hb_dq_sdr, hb_rwds_sdr};
    endfunction

    task automatic run_txn(input bit rd, input logic [31:0] addr, input logic [7:0] len,
                           input bit x2, input int unsigned xfer_prob, input int gap_after,
                           input int gap_len, input int abort_word, input bit expect_now,
                           input bit chain);
        logic [47:0] ca;
        logic [26:0] exp_bus;
        logic [15:0] exp_dq, exp_rd_data;
        logic [1:0]  exp_rwds;
        int n, lat, words, gap_left, idle_run, rwr_left, ca_idx, wait_n;
        ph_t ph;
        bit accepted, done, xfer, exp_rv, exp_last, exp_err, nxt_err;

        ca  = (48'(rd) << 47) | (48'd1 << 45) | (48'(addr >> 3) << 16) | 48'(addr & 32'd7);
        n   = (len == 8'd0) ? 256 : int'(len);
        lat = x2 ? 2 * LATENCY - 2 : LATENCY - 2;
        obs_rv = 0; obs_last_idx = 0; obs_wr = 0; obs_stall = 0;
        obs_lat = 0; obs_err = 0; obs_cs_high = 0;

        accepted = 0; wait_n = 0;
        while (!accepted) begin
            @(posedge iserdes_clkdiv); #1;
            cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = addr; cmd_len = len; rwds_lat_x2 = x2;
            rec_valid = 1'($urandom_range(1)); rec_data = 16'($urandom);
            wr_valid  = 1'($urandom_range(1)); wr_data = 16'($urandom); wr_mask = 2'($urandom);
            @(negedge iserdes_clkdiv);
            n_checks++;
            if (busy !== 1'b0 || hb_cs_n !== 1'b1 || rd_valid !== 1'b0 ||
                (expect_now && wait_n == 0 && cmd_ready !== 1'b1))
                $display("FAIL idle_wait: busy=%b cs_n=%b rd_valid=%b cmd_ready=%b required busy=0 cs_n=1 rd_valid=0 ready=%b",
                         busy, hb_cs_n, rd_valid, cmd_ready, expect_now);
            else n_pass++;
            if (cmd_ready === 1'b1) accepted = 1;
            else if (++wait_n >= 20) begin
                n_checks++;
                $display("FAIL cmd_accept_timeout: cmd_ready=%b after 20 cycles, required 1", cmd_ready);
                cmd_valid = 1'b0;
                return;
            end
        end

        ph = P_CA; ca_idx = 0; words = 0; gap_left = gap_len; idle_run = 0; rwr_left = 0;
        exp_rv = 0; exp_last = 0; exp_err = 0; exp_rd_data = '0; done = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(posedge iserdes_clkdiv); #1;
            cmd_valid = chain;
            xfer = ($urandom_range(99) < xfer_prob);
            if (ph == P_DATA && words == gap_after && gap_left > 0) begin
                xfer = 0; gap_left--;
            end
            rec_data = 16'($urandom); wr_data = 16'($urandom); wr_mask = 2'($urandom);
            if (ph == P_DATA) begin
                if (rd) begin rec_valid = xfer; wr_valid = 1'($urandom_range(1)); end
                else    begin wr_valid = xfer; rec_valid = 1'($urandom_range(1)); end
            end else begin
                xfer = 0;
                rec_valid = 1'($urandom_range(1)); wr_valid = 1'($urandom_range(1));
            end
            if (abort_word > 0 && ph == P_DATA && !rd && xfer && words == abort_word - 1) begin
                arst = 1'b1;
                @(negedge iserdes_clkdiv);
                n_checks++;
                if (obs_vec() !== RST_VEC)
                    $display("FAIL abort_outputs: got %h required %h", obs_vec(), RST_VEC);
                else n_pass++;
                return;
            end
            @(negedge iserdes_clkdiv);

            exp_dq = '0; exp_rwds = '0;
            if (ph == P_CA) exp_dq = 16'(ca >> (16 * (2 - ca_idx)));
            if (ph == P_DATA && !rd) begin exp_dq = wr_data; exp_rwds = wr_mask; end
            exp_bus = {(ph == P_RWR),
                       (ph == P_CA || ph == P_LAT || (ph == P_DATA && (rd || wr_valid))),
                       !(ph == P_CA || (ph == P_DATA && !rd)),
                       !(ph == P_DATA && !rd),
                       (ph == P_DATA && !rd),
                       1'b1, 1'b0, exp_rv, exp_err, exp_dq, exp_rwds};
            n_checks++;
            if (obs_vec() !== exp_bus)
                $display("FAIL bus_cycle%0d phase=%s: got %h required %h", cyc, ph.name(), obs_vec(), exp_bus);
            else n_pass++;
            if (exp_rv) begin
                n_checks++;
                if ({rd_data, rd_last} !== {exp_rd_data, exp_last})
                    $display("FAIL rd_word%0d: data=%h last=%b required data=%h last=%b",
                             obs_rv, rd_data, rd_last, exp_rd_data, exp_last);
                else n_pass++;
            end

            if (ph == P_CA) obs_ca[ca_idx] = hb_dq_sdr;
            if (rd_valid === 1'b1) begin obs_rv++; if (rd_last === 1'b1) obs_last_idx = obs_rv; end
            if (wr_ready === 1'b1 && wr_valid) obs_wr++;
            if (wr_ready === 1'b1 && hb_ck_en === 1'b0) obs_stall++;
            if (!rd && hb_cs_n === 1'b0 && hb_dq_t === 1'b1 && obs_wr == 0) obs_lat++;
            if (err_timeout === 1'b1) obs_err++;
            if (hb_cs_n === 1'b1) obs_cs_high++;

            nxt_err  = 0;
            exp_last = (ph == P_DATA && rd && rec_valid) && (words + 1 == n);
            exp_rd_data = rec_data;
            exp_rv   = (ph == P_DATA && rd && rec_valid);
            case (ph)
                P_CA:   begin ca_idx++; if (ca_idx == 3) ph = P_LAT; end
                P_LAT:  begin lat--; if (lat == 0) ph = P_DATA; end
                P_DATA: begin
                    if (xfer) begin words++; idle_run = 0; end
                    else idle_run++;
                    if (words == n) ph = P_HOLD;
`ifdef HBMC_RD_TIMEOUT_EN
                    else if (rd && idle_run == RD_TIMEOUT) begin ph = P_HOLD; nxt_err = 1; end
`endif
                end
                P_HOLD: begin ph = P_RWR; rwr_left = RWR_CYCLES; end
                P_RWR:  begin rwr_left--; if (rwr_left == 0) done = 1; end
                default: ;
            endcase
            exp_err = nxt_err;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL txn_complete: transaction not finished within 3000 cycles, phase=%s", ph.name());
        end
    endtask

    task automatic test_reset();
        arst = 1'b1; cmd_valid = 1'b0;
        repeat (5) @(posedge iserdes_clkdiv);
        @(negedge iserdes_clkdiv);
        n_checks++;
        if (obs_vec() !== RST_VEC) $display("FAIL reset_outputs: got %h required %h", obs_vec(), RST_VEC);
        else n_pass++;
        @(posedge iserdes_clkdiv); #1 arst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iserdes_clkdiv);
            n_checks++;
            if (cmd_ready !== (i == 2)) $display("FAIL reset_ready%0d: got %b required %b", i, cmd_ready, (i == 2));
            else n_pass++;
        end
    endtask

    task automatic test_read_basic();
        run_txn(1, 32'h0000_1235, 8'd4, 0, 70, -1, 0, 0, 0, 0);
        n_checks++;
        if ({obs_ca[0], obs_ca[1], obs_ca[2]} !== 48'hA000_0246_0005)
            $display("FAIL read_ca: got %h %h %h required a000 0246 0005", obs_ca[0], obs_ca[1], obs_ca[2]);
        else n_pass++;
        n_checks++;
        if (obs_rv != 4 || obs_last_idx != 4 || obs_err != 0)
            $display("FAIL read_count: rd_valid=%0d last_at=%0d err=%0d required 4 4 0", obs_rv, obs_last_idx, obs_err);
        else n_pass++;
        n_checks++;
        if (obs_cs_high != RWR_CYCLES) $display("FAIL read_rwr: got %0d required %0d", obs_cs_high, RWR_CYCLES);
        else n_pass++;
    endtask

    task automatic test_write_stall();
        run_txn(0, $urandom, 8'd2, 1, 100, 1, 3, 0, 0, 0);
        n_checks++;
        if (obs_wr != 2 || obs_stall != 3 || obs_lat != 10)
            $display("FAIL write_stall: words=%0d stalls=%0d lat=%0d required 2 3 10", obs_wr, obs_stall, obs_lat);
        else n_pass++;
    endtask

    task automatic test_read_len0();
        run_txn(1, $urandom, 8'd0, 0, 80, -1, 0, 0, 0, 0);
        n_checks++;
        if (obs_rv != 256 || obs_last_idx != 256)
            $display("FAIL len0_read: rd_valid=%0d last_at=%0d required 256 256", obs_rv, obs_last_idx);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            bit rd;
            logic [7:0] len;
            rd  = 1'($urandom_range(1));
            len = 8'($urandom_range(1, 20));
            run_txn(rd, $urandom, len, 1'($urandom_range(1)), $urandom_range(40, 100), -1, 0, 0, 0, 0);
            n_checks++;
            if ((rd ? obs_rv : obs_wr) != int'(len) || (rd && obs_last_idx != int'(len)))
                $display("FAIL random_txn%0d: words=%0d last_at=%0d required %0d", t,
                         rd ? obs_rv : obs_wr, obs_last_idx, len);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        run_txn(1, $urandom, 8'd8, 0, 100, 3, 40, 0, 0, 0);
        n_checks++;
`ifdef HBMC_RD_TIMEOUT_EN
        if (obs_err != 1 || obs_rv != 3)
            $display("FAIL rd_timeout: err_pulses=%0d rd_valid=%0d required 1 3", obs_err, obs_rv);
`else
        if (obs_err != 0 || obs_rv != 8)
            $display("FAIL rd_no_timeout: err_pulses=%0d rd_valid=%0d required 0 8", obs_err, obs_rv);
`endif
        else n_pass++;
    endtask

    task automatic test_arst_mid_write();
        run_txn(0, $urandom, 8'd4, 0, 100, -1, 0, 2, 0, 0);
        @(posedge iserdes_clkdiv); #1 arst = 1'b0;
        run_txn(0, $urandom, 8'd3, 1, 80, -1, 0, 0, 0, 0);
        n_checks++;
        if (obs_wr != 3) $display("FAIL post_abort_write: words=%0d required 3", obs_wr);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        a = $urandom;
        run_txn(0, a, 8'd3, 0, 100, -1, 0, 0, 0, 1);
        n_checks++;
        if (obs_cs_high != RWR_CYCLES) $display("FAIL b2b_gap: cs_n high=%0d required %0d", obs_cs_high, RWR_CYCLES);
        else n_pass++;
        run_txn(0, a, 8'd3, 0, 100, -1, 0, 0, 1, 0);
        n_checks++;
        if (obs_wr != 3) $display("FAIL b2b_second: words=%0d required 3", obs_wr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_stall();
        test_read_len0();
        test_random();
        test_timeout();
        test_arst_mid_write();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
